// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB permit arbiter with per-requester starvation tracking
// Optional per-requester permit counters enabled by CDB_ARB_GRANT_COUNT_EN.
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_WIDTH    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   request,
  input  logic                 bus_stall,
  output logic [NUM_REQ-1:0]   permit,
  output logic                 grant_valid,
  output logic [IDX_WIDTH-1:0] grant_index,
  output logic [IDX_WIDTH-1:0] priority_ptr,
  output logic                 starve_error
`ifdef CDB_ARB_GRANT_COUNT_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_count
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

  logic                 cand_found;
  logic [IDX_WIDTH-1:0] cand_idx;
  logic [7:0]           wait_cnt  [NUM_REQ];
  logic [7:0]           wait_next [NUM_REQ];
  logic                 starve_hit;

  // Scan from the pointer with an explicit wrap so non-power-of-two NUM_REQ works.
  always_comb begin
    int j;
    cand_found = 1'b0;
    cand_idx   = '0;
    j          = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(priority_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!cand_found && request[j]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_WIDTH'(j);
      end
    end
  end

  // Reset gates the permit so no buffer drives the bus while the arbiter is held.
  always_comb begin
    permit = '0;
    if (reset && !bus_stall && cand_found) permit = NUM_REQ'(1) << cand_idx;
  end

  assign grant_valid = |permit;
  assign grant_index = grant_valid ? cand_idx : '0;

  always_comb begin
    starve_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_next[i] = 8'd0;
      if (request[i] && !permit[i])
        wait_next[i] = (wait_cnt[i] >= LIMIT) ? LIMIT : wait_cnt[i] + 8'd1;
      if (wait_next[i] == LIMIT) starve_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      priority_ptr <= '0;
      starve_error <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= 8'd0;
    end else begin
      if (grant_valid)
        priority_ptr <= (grant_index == LAST_IDX) ? '0 : grant_index + IDX_WIDTH'(1);
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= wait_next[i];
      if (starve_hit) starve_error <= 1'b1;
    end
  end

`ifdef CDB_ARB_GRANT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (permit[i]) grant_count[16*i +: 16] <= grant_count[16*i +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a queue-free behavioural model
module tb_cdb_arbiter;

  localparam int N     = 4;
  localparam int LIMIT = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] request;
  logic         bus_stall;
  logic [N-1:0] permit;
  logic         grant_valid;
  logic [1:0]   grant_index;
  logic [1:0]   priority_ptr;
  logic         starve_error;
`ifdef CDB_ARB_GRANT_COUNT_EN
  logic [N*16-1:0] grant_count;
`endif

  cdb_arbiter #(.NUM_REQ(N), .IDX_WIDTH(2), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .reset(reset),
    .request(request),
    .bus_stall(bus_stall),
    .permit(permit),
    .grant_valid(grant_valid),
    .grant_index(grant_index),
    .priority_ptr(priority_ptr),
    .starve_error(starve_error)
`ifdef CDB_ARB_GRANT_COUNT_EN
    ,
    .grant_count(grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: the pointer, the wait ages and the sticky flag, all as plain integers.
  int m_ptr;
  int m_wait [N];
  bit m_starve;
  int m_cnt  [N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (request[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int granted();
    if (!reset || bus_stall) return -1;
    return winner();
  endfunction

  task automatic drive(input logic rst, input logic [N-1:0] req, input logic stall);
    @(negedge clk);
    reset     = rst;
    request   = req;
    bus_stall = stall;
    #1;
  endtask

  task automatic check_model();
    int g;
    g = granted();
    check_val("permit", 32'(permit), (g < 0) ? 32'd0 : 32'(1) << g);
    check_val("grant_valid", 32'(grant_valid), (g < 0) ? 32'd0 : 32'd1);
    check_val("grant_index", 32'(grant_index), (g < 0) ? 32'd0 : 32'(g));
    check_val("priority_ptr", 32'(priority_ptr), 32'(m_ptr));
    check_val("starve_error", 32'(starve_error), 32'(m_starve));
`ifdef CDB_ARB_GRANT_COUNT_EN
    for (int i = 0; i < N; i++)
      check_val("grant_count", 32'(grant_count[16*i +: 16]), 32'(m_cnt[i]));
`endif
  endtask

  task automatic step();
    int g;
    g = granted();
    @(posedge clk);
    if (!reset) begin
      m_ptr = 0;
      m_starve = 0;
      for (int i = 0; i < N; i++) begin
        m_wait[i] = 0;
        m_cnt[i]  = 0;
      end
    end else begin
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        m_cnt[g] = (m_cnt[g] + 1) % 65536;
      end
      for (int i = 0; i < N; i++) begin
        if (request[i] && g != i) m_wait[i] = (m_wait[i] + 1 > LIMIT) ? LIMIT : m_wait[i] + 1;
        else m_wait[i] = 0;
        if (m_wait[i] == LIMIT) m_starve = 1;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic [N-1:0] req, input logic stall);
    drive(rst, req, stall);
    check_model();
    step();
  endtask

  initial begin
    m_ptr = 0;
    m_starve = 0;
    for (int i = 0; i < N; i++) begin
      m_wait[i] = 0;
      m_cnt[i]  = 0;
    end
    reset = 1'b0; request = '0; bus_stall = 1'b0;

    // Reset with everything requesting: permit must stay quiet.
    cycle(1'b0, 4'b1111, 1'b0);
    cycle(1'b0, 4'b1111, 1'b0);

    // Full request set rotates 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'b1111, 1'b0);
      check_model();
      check_val("rr_index", 32'(grant_index), 32'(k % 4));
      step();
    end
    check_val("rr_starve", 32'(starve_error), 32'd0);

    // Pointer at 2 with only buffers 0 and 1 requesting wraps to 0, then 1.
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0);
    drive(1'b1, 4'b0011, 1'b0);
    check_val("wrap_ptr2", 32'(priority_ptr), 32'd2);
    check_val("wrap_permit", 32'(permit), 32'b0001);
    step();
    drive(1'b1, 4'b0011, 1'b0);
    check_val("wrap_ptr1", 32'(priority_ptr), 32'd1);
    check_val("wrap_next", 32'(permit), 32'b0010);
    step();

    // Stalled requester reaches the starvation limit on the 8th edge.
    cycle(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'b0100, 1'b1);
      check_model();
      check_val("stall_permit", 32'(permit), 32'd0);
      step();
      #1;
      check_val("stall_starve", 32'(starve_error), (k == 7) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 4'b0100, 1'b0);
    check_val("release_permit", 32'(permit), 32'b0100);
    check_val("release_starve", 32'(starve_error), 32'd1);
    step();

    // Reset mid-stream clears state; first grant afterwards goes to index 1.
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 4'b1010, 1'b0);
    drive(1'b0, 4'b1010, 1'b0);
    check_val("midrst_permit", 32'(permit), 32'd0);
    step();
    drive(1'b1, 4'b1010, 1'b0);
    check_val("midrst_ptr", 32'(priority_ptr), 32'd0);
    check_val("midrst_starve", 32'(starve_error), 32'd0);
    check_val("midrst_first", 32'(grant_index), 32'd1);
    step();

    // Randomized traffic with occasional stalls and resets.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 59) != 0), 4'($urandom), ($urandom_range(0, 3) == 0));
      check_val("onehot", 32'($onehot0(permit)), 32'd1);
      check_val("subset", 32'(permit & ~request), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
